// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader: serves HPS save-file upload requests from the save RAM.
//
// When ioctl_upload rises, the block takes ownership of the save-RAM port
// (ram_owner), waits one cycle for the bus handover, then answers each one-cycle
// ioctl_rd strobe. An in-range request issues a ram_rd and returns ram_q on
// ioctl_din after RAM_LAT+1 wait cycles; an out-of-range request returns 8'hFF,
// sets the sticky err_range flag and holds ioctl_wait for a single cycle. When
// ioctl_upload drops, any pending fetch completes, done pulses once and
// ownership is released.
//
// Ports
//   clk_sys      in   single clock
//   reset        in   synchronous active-high reset
//   ioctl_upload in   high for the whole upload session
//   ioctl_rd     in   one-cycle byte request strobe
//   ioctl_addr   in   requested byte address (25 bits)
//   ioctl_din    out  byte returned to the HPS
//   ioctl_wait   out  high while a byte is pending
//   ram_addr     out  save-RAM read address
//   ram_rd       out  one-cycle save-RAM read strobe
//   ram_q        in   save-RAM read data, valid RAM_LAT cycles after ram_rd
//   ram_owner    out  high while this block owns the save-RAM port
//   done         out  one-cycle pulse at session end
//   err_range    out  sticky out-of-range request flag, cleared at session start

module nvram_upload_reader #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic [7:0]        ram_q,
   output logic              ram_owner,
   output logic              done,
   output logic              err_range
);

   typedef enum logic [2:0] {StIdle, StArm, StReady, StFetch, StFinish} state_e;

   state_e            state_q, state_d;
   logic              upload_q;
   logic              seen_low_q;
   logic [2:0]        cnt_q, cnt_d;

   logic [7:0]        din_d;
   logic              wait_d;
   logic [ADDR_W-1:0] ram_addr_d;
   logic              ram_rd_d;
   logic              owner_d;
   logic              done_d;
   logic              err_d;

   logic              upload_rise;
   logic              in_range;

   // seen_low_q blocks a session start after reset until ioctl_upload has been
   // observed low, so an upload held high across reset cannot restart a session.
   assign upload_rise = ioctl_upload & ~upload_q & seen_low_q;

   // Every upper address bit must be zero; high addresses never alias onto RAM.
   assign in_range = ((ioctl_addr >> ADDR_W) == 25'd0);

   // State and registered outputs
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= StIdle;
         upload_q   <= 1'b0;
         seen_low_q <= 1'b0;
         cnt_q      <= 3'd0;
         ioctl_din  <= 8'd0;
         ioctl_wait <= 1'b0;
         ram_addr   <= '0;
         ram_rd     <= 1'b0;
         ram_owner  <= 1'b0;
         done       <= 1'b0;
         err_range  <= 1'b0;
      end else begin
         state_q    <= state_d;
         upload_q   <= ioctl_upload;
         seen_low_q <= seen_low_q | ~ioctl_upload;
         cnt_q      <= cnt_d;
         ioctl_din  <= din_d;
         ioctl_wait <= wait_d;
         ram_addr   <= ram_addr_d;
         ram_rd     <= ram_rd_d;
         ram_owner  <= owner_d;
         done       <= done_d;
         err_range  <= err_d;
      end
   end

   // Next-state logic. Session end is taken from the ioctl_upload level in
   // READY, so a drop that happens while still in ARM is not lost.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (upload_rise) state_d = StArm;
         end
         StArm: begin
            state_d = StReady;
         end
         StReady: begin
            if (!ioctl_upload) begin
               state_d = StFinish;
            end else if (ioctl_rd && in_range) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (cnt_q == 3'd0) state_d = ioctl_upload ? StReady : StFinish;
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Output next-values
   always_comb begin
      din_d      = ioctl_din;
      wait_d     = 1'b0;
      ram_addr_d = ram_addr;
      ram_rd_d   = 1'b0;
      owner_d    = ram_owner;
      done_d     = 1'b0;
      err_d      = err_range;
      cnt_d      = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (upload_rise) begin
               owner_d = 1'b1;
               err_d   = 1'b0;
            end
         end
         StArm: begin
         end
         StReady: begin
            if (ioctl_upload && ioctl_rd) begin
               wait_d = 1'b1;
               if (in_range) begin
                  ram_addr_d = ioctl_addr[ADDR_W-1:0];
                  ram_rd_d   = 1'b1;
                  cnt_d      = 3'(RAM_LAT);
               end else begin
                  // Staying in READY drops ioctl_wait again on the next edge.
                  din_d = 8'hFF;
                  err_d = 1'b1;
               end
            end
         end
         StFetch: begin
            if (cnt_q == 3'd0) begin
               din_d = ram_q;
            end else begin
               cnt_d  = cnt_q - 3'd1;
               wait_d = 1'b1;
            end
         end
         StFinish: begin
            done_d  = 1'b1;
            owner_d = 1'b0;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_nvram_upload_reader.sv
module tb_nvram_upload_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        upload;
   logic        rd;
   logic [24:0] addr;

   // Instance a: RAM_LAT=1, instance b: RAM_LAT=3. Both see the same stimulus;
   // sel picks whose outputs the checks observe.
   logic [7:0] din_a, din_b, q_a, q_b;
   logic       wait_a, wait_b, rd_a, rd_b, own_a, own_b, done_a, done_b, err_a, err_b;
   logic [9:0] raddr_a, raddr_b;

   nvram_upload_reader #(.ADDR_W(10), .RAM_LAT(1)) dut_a (
      .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd),
      .ioctl_addr(addr), .ioctl_din(din_a), .ioctl_wait(wait_a), .ram_addr(raddr_a),
      .ram_rd(rd_a), .ram_q(q_a), .ram_owner(own_a), .done(done_a), .err_range(err_a)
   );

   nvram_upload_reader #(.ADDR_W(10), .RAM_LAT(3)) dut_b (
      .clk_sys(clk), .reset(reset), .ioctl_upload(upload), .ioctl_rd(rd),
      .ioctl_addr(addr), .ioctl_din(din_b), .ioctl_wait(wait_b), .ram_addr(raddr_b),
      .ram_rd(rd_b), .ram_q(q_b), .ram_owner(own_b), .done(done_b), .err_range(err_b)
   );

   // Save-RAM models: data is valid only in the exact cycle RAM_LAT after ram_rd,
   // otherwise 8'hEE, so mistimed captures show up as wrong bytes.
   logic [7:0] mem [1024];
   logic [7:0] pipe_a;
   logic [7:0] pipe_b [3];
   always @(posedge clk) begin
      pipe_a     <= rd_a ? mem[raddr_a] : 8'hEE;
      pipe_b[0]  <= rd_b ? mem[raddr_b] : 8'hEE;
      pipe_b[1]  <= pipe_b[0];
      pipe_b[2]  <= pipe_b[1];
   end
   assign q_a = pipe_a;
   assign q_b = pipe_b[2];

   logic       sel = 1'b0;
   logic [7:0] m_din;
   logic       m_wait, m_rd, m_own, m_done, m_err;
   logic [9:0] m_raddr;
   assign m_din   = sel ? din_b   : din_a;
   assign m_wait  = sel ? wait_b  : wait_a;
   assign m_rd    = sel ? rd_b    : rd_a;
   assign m_own   = sel ? own_b   : own_a;
   assign m_done  = sel ? done_b  : done_a;
   assign m_err   = sel ? err_b   : err_a;
   assign m_raddr = sel ? raddr_b : raddr_a;

   int n_checks = 0;
   int n_errors = 0;
   int rdcnt    = 0;
   int donecnt  = 0;
   logic [7:0] expq [$];

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Pulse counters (values sampled just before each edge = previous cycle)
   initial forever begin
      @(posedge clk);
      if (m_rd) rdcnt++;
      if (m_done) donecnt++;
   end

   // Scoreboard monitor: a byte is presented when ioctl_wait falls, except when
   // the fall was caused by reset.
   initial begin
      logic       wait_prev;
      logic       rst_prev;
      logic [7:0] exp;
      wait_prev = 1'b0;
      rst_prev  = 1'b1;
      forever begin
         @(negedge clk);
         if (wait_prev && !m_wait && !rst_prev) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL scoreboard: unexpected byte 0x%0h, none required", m_din);
            end else begin
               exp = expq.pop_front();
               check("scoreboard din", m_din, exp);
            end
         end
         wait_prev = m_wait;
         rst_prev  = reset;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_low(output int wcnt);
      wcnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_wait) wcnt++;
         else break;
      end
   endtask

   task automatic do_read(input logic [24:0] a, input logic [7:0] exp, output int wcnt);
      @(posedge clk); #1;
      rd   = 1'b1;
      addr = a;
      expq.push_back(exp);
      @(posedge clk); #1;
      rd   = 1'b0;
      addr = '0;
      wait_low(wcnt);
   endtask

   task automatic start_session();
      @(posedge clk); #1;
      upload = 1'b1;
      cyc(2);
      check("owner at session start", m_own, 1);
   endtask

   task automatic end_session(input string name);
      int d0;
      d0 = donecnt;
      @(posedge clk); #1;
      upload = 1'b0;
      cyc(8);
      check({name, " done pulses"}, donecnt - d0, 1);
      check({name, " owner released"}, m_own, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " din"}, m_din, 0);
      check({name, " wait"}, m_wait, 0);
      check({name, " ram_addr"}, m_raddr, 0);
      check({name, " ram_rd"}, m_rd, 0);
      check({name, " owner"}, m_own, 0);
      check({name, " done"}, m_done, 0);
      check({name, " err"}, m_err, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required earlier finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, r0, d0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 13 + 7) ^ 8'(i >> 2);
      mem[5] = 8'h5A;
      reset  = 1'b1;
      upload = 1'b0;
      rd     = 1'b0;
      addr   = '0;
      cyc(3);
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // ioctl_rd while idle is ignored
      r0 = rdcnt;
      @(posedge clk); #1; rd = 1'b1; addr = 25'd5;
      @(posedge clk); #1; rd = 1'b0; addr = '0;
      @(negedge clk);
      check("idle rd wait", m_wait, 0);
      cyc(2);
      check("idle rd ram_rd", rdcnt - r0, 0);

      // Session 1: basic read then full sweep (RAM_LAT=1)
      start_session();
      check("err clear at start", m_err, 0);
      r0 = rdcnt;
      do_read(25'h005, 8'h5A, w);
      check("basic wait cycles", w, 2);
      check("basic ram_rd count", rdcnt - r0, 1);
      check("basic ram_addr", m_raddr, 10'h005);
      r0 = rdcnt;
      for (int i = 0; i < 1024; i++) begin
         do_read(25'(i), mem[i], w);
         if (w != 2) check("sweep wait cycles", w, 2);
      end
      check("sweep ram_rd count", rdcnt - r0, 1024);
      check("sweep err", m_err, 0);
      end_session("sweep");
      check("din holds after finish", m_din, mem[1023]);

      // Session 2: out-of-range requests
      start_session();
      r0 = rdcnt;
      do_read(25'h400, 8'hFF, w);
      check("oor wait cycles", w, 1);
      check("oor ram_rd count", rdcnt - r0, 0);
      check("oor err", m_err, 1);
      r0 = rdcnt;
      do_read(25'h1000005, 8'hFF, w);
      check("high addr wait cycles", w, 1);
      check("high addr no wrap", rdcnt - r0, 0);
      do_read(25'h3FF, mem[1023], w);
      check("in range after oor wait", w, 2);
      check("err sticky", m_err, 1);
      end_session("oor");

      // Session 3: start clears err_range
      start_session();
      check("err cleared by new session", m_err, 0);
      end_session("s3");

      // Upload pulse shorter than ARM still yields exactly one done
      d0 = donecnt;
      @(posedge clk); #1; upload = 1'b1;
      @(posedge clk); #1; upload = 1'b0;
      cyc(8);
      check("short session done", donecnt - d0, 1);
      check("short session owner", m_own, 0);

      // Switch to the RAM_LAT=3 instance
      cyc(4);
      sel = 1'b1;
      cyc(2);

      start_session();
      do_read(25'h02A, mem[42], w);
      check("lat3 wait cycles", w, 4);

      // Upload drop plus stray rd one cycle after a valid request
      r0 = rdcnt;
      d0 = donecnt;
      @(posedge clk); #1; rd = 1'b1; addr = 25'h123;
      expq.push_back(mem[291]);
      @(posedge clk); #1; rd = 1'b1; addr = 25'h200; upload = 1'b0;
      @(posedge clk); #1; rd = 1'b0; addr = '0;
      wait_low(w);
      check("overlap wait ends", m_wait, 0);
      cyc(8);
      check("overlap ram_rd count", rdcnt - r0, 1);
      check("overlap done", donecnt - d0, 1);
      check("overlap owner", m_own, 0);
      check("overlap din", m_din, mem[291]);

      // Reset during FETCH with upload held high
      start_session();
      d0 = donecnt;
      @(posedge clk); #1; rd = 1'b1; addr = 25'h007;
      @(posedge clk); #1; rd = 1'b0; addr = '0;
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("midfetch reset");
      cyc(6);
      check("midfetch no done", donecnt - d0, 0);
      check("midfetch no restart", m_own, 0);
      r0 = rdcnt;
      @(posedge clk); #1; rd = 1'b1; addr = 25'h009;
      @(posedge clk); #1; rd = 1'b0; addr = '0;
      cyc(3);
      check("post reset rd ignored", rdcnt - r0, 0);
      check("post reset wait", m_wait, 0);
      @(posedge clk); #1; upload = 1'b0;
      cyc(2);
      start_session();
      do_read(25'h009, mem[9], w);
      check("fresh session wait cycles", w, 4);
      end_session("fresh");

      cyc(4);
      check("scoreboard drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nvram_upload_reader.md
NVRAM_UPLOAD_READER -- requirements
Module: nvram_upload_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the width of the save-RAM address (the save region is 2^ADDR_W bytes).
REQ-002 SHALL have parameter RAM_LAT, default 1, range 1..4, meaning the number of clk_sys cycles from ram_rd to valid ram_q.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ioctl_upload, input, 1 bit: high for the whole HPS upload session.
REQ-006 SHALL have port ioctl_rd, input, 1 bit: one-cycle byte request strobe.
REQ-007 SHALL have port ioctl_addr, input, 25 bits: the requested byte address, valid while ioctl_rd is high.
REQ-008 SHALL have port ioctl_din, output, 8 bits: the byte returned to the HPS.
REQ-009 SHALL have port ioctl_wait, output, 1 bit: high while a byte is pending; the HPS SHALL NOT issue ioctl_rd while it is high.
REQ-010 SHALL have port ram_addr, output, ADDR_W bits: the save-RAM read address.
REQ-011 SHALL have port ram_rd, output, 1 bit: one-cycle save-RAM read strobe.
REQ-012 SHALL have port ram_q, input, 8 bits: save-RAM read data.
REQ-013 SHALL have port ram_owner, output, 1 bit: high while this block owns the save-RAM port (the game-side port is muxed away).
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at session end.
REQ-015 SHALL have port err_range, output, 1 bit: sticky flag, set by an out-of-range request.

Function
REQ-016 SHALL be a registered FSM with states IDLE, ARM, READY, FETCH, FINISH; all outputs registered.
REQ-017 SHALL detect an ioctl_upload rising edge from a registered copy of the previous value.
REQ-018 In IDLE, an ioctl_upload rising edge SHALL move the FSM to ARM, set ram_owner=1 and clear err_range.
REQ-019 ARM SHALL last exactly one cycle (bus handover), then move to READY.
REQ-020 In READY, ioctl_rd=1 with ioctl_addr < 2^ADDR_W at cycle t SHALL, on the edge ending t: set ram_addr=ioctl_addr[ADDR_W-1:0], pulse ram_rd (one cycle), set ioctl_wait=1, load the latency counter with RAM_LAT, and move to FETCH.
REQ-021 FETCH SHALL decrement the counter each cycle; when the counter reaches 0 it SHALL capture ram_q into ioctl_din, clear ioctl_wait in that same edge, and return to READY.
REQ-022 The resulting handshake SHALL be: ioctl_wait high for cycles t+1..t+RAM_LAT+1; ioctl_din valid and ioctl_wait low from cycle t+RAM_LAT+2.
REQ-023 In READY, ioctl_rd with ioctl_addr >= 2^ADDR_W SHALL set ioctl_din=8'hFF, set err_range=1, hold ioctl_wait high for exactly one cycle, and SHALL NOT pulse ram_rd.
REQ-024 ioctl_rd asserted in FETCH, ARM or FINISH SHALL be ignored; it SHALL NOT restart or corrupt the pending fetch.
REQ-025 An ioctl_upload falling edge in READY SHALL move the FSM to FINISH.
REQ-026 An ioctl_upload falling edge in FETCH SHALL first complete the fetch (REQ-021), then move to FINISH.
REQ-027 FINISH SHALL pulse done for one cycle, clear ram_owner, and move to IDLE; ioctl_din SHALL hold its last value.
REQ-028 ioctl_rd in IDLE SHALL be ignored: no ram_rd, ioctl_wait stays 0.
REQ-029 ioctl_upload high and low within the same ARM cycle SHALL still pass through READY and then FINISH, giving exactly one done pulse.
REQ-030 Address comparison SHALL use all 25 ioctl_addr bits; there SHALL be no silent wrap of high addresses onto the RAM.

Reset
REQ-031 reset=1 SHALL force state IDLE and set ioctl_din=0, ioctl_wait=0, ram_addr=0, ram_rd=0, ram_owner=0, done=0, err_range=0, counter=0, and the upload-edge register=0.
REQ-032 reset asserted mid-session or mid-fetch SHALL abort without a done pulse; if ioctl_upload is still high after reset, no new session SHALL start until a fresh rising edge.

Verification
REQ-033 Basic read, RAM_LAT=1, RAM[0x005]=0x5A: upload rise, ioctl_rd at addr 0x005 -> ram_rd one cycle with ram_addr=0x005; ioctl_wait high for 2 cycles; then ioctl_din=0x5A and ioctl_wait=0.
REQ-034 Full sweep: read addrs 0..1023 in order, next ioctl_rd issued right after wait falls -> 1024 bytes match RAM contents, err_range=0; upload fall -> done pulses once, ram_owner=0.
REQ-035 Out of range: ioctl_rd at addr 0x400 -> ioctl_din=0xFF, err_range=1, no ram_rd, wait high for 1 cycle; the next session start clears err_range.
REQ-036 Overlap: RAM_LAT=3, ioctl_upload falls and a stray ioctl_rd arrives 1 cycle after a valid request -> original byte returned, stray ignored, then done pulses.
REQ-037 Reset mid-fetch: reset during FETCH with ioctl_upload held high -> all outputs 0, no done pulse, no activity until ioctl_upload goes low then high.
